// File: rtl/adc_frame_packer.sv
// adc_frame_packer: gathers one sample per ADC channel into a set, buffers
// sets in a frame FIFO, and serialises each set as
//   SYNC, SEQ, FLAGS, ch0 bytes .. chN-1 bytes [, CSUM]
// toward a byte-wide ready/valid sink.
// Optional build macro: ADC_FRAME_CHECKSUM_EN appends an XOR checksum byte
// covering SEQ, FLAGS and all data bytes.
module adc_frame_packer #(
  parameter int         NCH        = 2,
  parameter int         SAMPLE_W   = 24,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NCH-1:0]                sample_valid,
  input  logic [NCH*SAMPLE_W-1:0]       sample_data,
  input  logic [NCH-1:0]                sample_ovfl,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);
  localparam int SB = (SAMPLE_W + 7) / 8;   // bytes per sample on the wire
  localparam int NB = NCH * SB;             // data bytes per frame
  localparam int DW = NB * 8;
  localparam int SW = NCH * SAMPLE_W;
  localparam int RW = 16 + SW;              // record: {seq, flags, samples}
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL   = (AW+1)'(FIFO_DEPTH);
  localparam logic [5:0]  LAST_B = 6'(NB - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_SEQ   = 3'd2;
  localparam logic [2:0] S_FLAGS = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
`ifdef ADC_FRAME_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd5;
`endif

  // ---------------- holding stage ----------------
  logic [SW-1:0]  hold, set_data;
  logic [NCH-1:0] have, hold_ovfl, have_nxt, ovfl_nxt;
  logic [7:0]     seq, flags_nxt;
  logic           drop_pending, complete;

  // Merge this edge's strobes into the set so a strobe on the completing
  // edge lands in the completing set rather than the next one.
  always_comb begin
    have_nxt  = have | sample_valid;
    ovfl_nxt  = hold_ovfl | (sample_valid & sample_ovfl);
    set_data  = hold;
    for (int i = 0; i < NCH; i++)
      if (sample_valid[i]) set_data[i*SAMPLE_W +: SAMPLE_W] = sample_data[i*SAMPLE_W +: SAMPLE_W];
    flags_nxt = '0;
    flags_nxt[NCH-1:0] = ovfl_nxt;
    flags_nxt[7]       = drop_pending;
    complete  = &have_nxt;
  end

  // Holding registers: a repeat strobe overwrites the sample, ovfl is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold      <= '0;
      have      <= '0;
      hold_ovfl <= '0;
    end else begin
      hold      <= set_data;
      have      <= complete ? '0 : have_nxt;
      hold_ovfl <= complete ? '0 : ovfl_nxt;
    end
  end

  // ---------------- frame FIFO ----------------
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          wr, pop, empty, full;
  logic [RW-1:0] rd_rec;

  assign empty      = (count == '0);
  assign full       = (count == FULL);
  // A pop on the completion edge frees the slot the write needs.
  assign wr         = complete && (!full || pop);
  assign rd_rec     = mem[rptr];
  assign fifo_level = count;

  // Record storage; contents need no reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {seq, flags_nxt, set_data};
  end

  // Pointers, occupancy, sequence number and drop accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      seq          <= '0;
      drop_pending <= 1'b0;
      drop_count   <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (complete) begin
        // seq advances even on a drop so the host sees the gap
        seq <= seq + 8'd1;
        if (wr) drop_pending <= 1'b0;
        else begin
          drop_pending <= 1'b1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

  // ---------------- serializer ----------------
  logic [2:0]    state;
  logic [7:0]    f_seq, f_flags;
  logic [DW-1:0] ext, dsh;
  logic [5:0]    bcnt;
  logic          acc, frame_end;
`ifdef ADC_FRAME_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // Sign-extend each popped sample to SB bytes, channel 0 in the top bytes.
  for (genvar i = 0; i < NCH; i++) begin : g_ext
    logic signed [SAMPLE_W-1:0] s;
    assign s = rd_rec[i*SAMPLE_W +: SAMPLE_W];
    assign ext[DW-1-i*SB*8 -: SB*8] = (SB*8)'(s);
  end

  assign out_valid = (state != S_IDLE);
  assign acc       = out_valid && out_ready;
`ifdef ADC_FRAME_CHECKSUM_EN
  assign frame_end = acc && (state == S_CSUM);
`else
  assign frame_end = acc && (state == S_DATA) && (bcnt == LAST_B);
`endif
  // Back-to-back frames: pop on the last byte's acceptance, no idle gap.
  assign pop = !empty && ((state == S_IDLE) || frame_end);

  // Byte presented in each state; all sources are registers so the byte
  // holds steady while the sink stalls.
  always_comb begin
    case (state)
      S_SYNC:  out_data = SYNC_BYTE;
      S_SEQ:   out_data = f_seq;
      S_FLAGS: out_data = f_flags;
      S_DATA:  out_data = dsh[DW-1 -: 8];
`ifdef ADC_FRAME_CHECKSUM_EN
      S_CSUM:  out_data = csum;
`endif
      default: out_data = 8'h00;
    endcase
  end

  // Frame FSM: load on pop, advance one byte per accepted handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      f_seq   <= '0;
      f_flags <= '0;
      dsh     <= '0;
      bcnt    <= '0;
`ifdef ADC_FRAME_CHECKSUM_EN
      csum    <= '0;
`endif
    end else if (pop) begin
      state   <= S_SYNC;
      f_seq   <= rd_rec[RW-1 -: 8];
      f_flags <= rd_rec[RW-9 -: 8];
      dsh     <= ext;
      bcnt    <= '0;
`ifdef ADC_FRAME_CHECKSUM_EN
      csum    <= '0;
`endif
    end else if (frame_end) begin
      state <= S_IDLE;
    end else if (acc) begin
`ifdef ADC_FRAME_CHECKSUM_EN
      if (state != S_SYNC) csum <= csum ^ out_data;
`endif
      case (state)
        S_SYNC:  state <= S_SEQ;
        S_SEQ:   state <= S_FLAGS;
        S_FLAGS: state <= S_DATA;
        S_DATA: begin
          dsh  <= dsh << 8;
          bcnt <= bcnt + 6'd1;
`ifdef ADC_FRAME_CHECKSUM_EN
          if (bcnt == LAST_B) state <= S_CSUM;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
